// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: handshake bundle between the EX issue logic, the iterative
// divider controller and the EX result mux.
//   master : issue/consumer side (drives request, flush and out_ready)
//   slave  : divider controller (drives div_ready, out_valid, div_result, div_busy)
interface ex_div_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            div_valid;
  logic            div_ready;
  logic            div_signed;
  logic            div_mod;
  logic [XLEN-1:0] div_src1;
  logic [XLEN-1:0] div_src2;
  logic            div_flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] div_result;
  logic            div_busy;

  modport master (
    output div_valid, div_signed, div_mod, div_src1, div_src2, div_flush, out_ready,
    input  div_ready, out_valid, div_result, div_busy
  );

  modport slave (
    input  div_valid, div_signed, div_mod, div_src1, div_src2, div_flush, out_ready,
    output div_ready, out_valid, div_result, div_busy
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu.
// Operands are converted to magnitudes on accept, 32 iterations run on a shared
// 33-bit subtractor, and the sign fix-up happens on entry to DONE.
// Ports:
//   clk, resetn : core clock, asynchronous active-low reset
//   bus (slave) : request handshake (div_valid/div_ready, operands, div_flush),
//                 result handshake (out_valid/out_ready, div_result), div_busy
// Optional: define DIV_ZERO_FAST_EN to send divide-by-zero straight IDLE -> DONE.
module ex_div_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  ex_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic              mod_q, mod_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic              div_ready_q, div_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              div_busy_q, div_busy_d;
  logic [XLEN-1:0]   div_result_q, div_result_d;

  logic [XLEN:0]     trial;
  logic              in_sign1, in_sign2;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN-1:0]   q_fix, r_fix;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sign1_d      = sign1_q;
    sign2_d      = sign2_q;
    mod_d        = mod_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    div_result_d = div_result_q;

    trial    = {rem_q, dvd_q[XLEN-1]} - {1'b0, dvs_q};
    in_sign1 = bus.div_signed & bus.div_src1[XLEN-1];
    in_sign2 = bus.div_signed & bus.div_src2[XLEN-1];
    abs1     = in_sign1 ? (XLEN'(0) - bus.div_src1) : bus.div_src1;
    abs2     = in_sign2 ? (XLEN'(0) - bus.div_src2) : bus.div_src2;

    unique case (state_q)
      IDLE: begin
        // div_ready is high exactly in IDLE, so it is implied here
        if (bus.div_valid && !bus.div_flush) begin
          sign1_d = in_sign1;
          sign2_d = in_sign2;
          mod_d   = bus.div_mod;
          dvd_d   = abs1;
          dvs_d   = abs2;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
          // Same values the full iteration would produce for a zero divisor
          if (bus.div_src2 == '0) begin
            quot_d  = '1;
            rem_d   = abs1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        // trial[XLEN] set means the subtraction went negative: restore
        rem_d  = trial[XLEN] ? {rem_q[XLEN-2:0], dvd_q[XLEN-1]} : trial[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], ~trial[XLEN]};
        dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything, including a same-cycle accept or out_ready
    if (bus.div_flush) begin
      state_d = IDLE;
    end

    q_fix = (sign1_d ^ sign2_d) ? (XLEN'(0) - quot_d) : quot_d;
    r_fix = sign1_d ? (XLEN'(0) - rem_d) : rem_d;

    // Capture the result once on entry to DONE so it holds under backpressure
    if ((state_d == DONE) && (state_q != DONE)) begin
      div_result_d = mod_d ? r_fix : q_fix;
    end

    div_ready_d = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    div_busy_d  = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      mod_q        <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      div_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      div_busy_q   <= 1'b0;
      div_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sign1_q      <= sign1_d;
      sign2_q      <= sign2_d;
      mod_q        <= mod_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      div_ready_q  <= div_ready_d;
      out_valid_q  <= out_valid_d;
      div_busy_q   <= div_busy_d;
      div_result_q <= div_result_d;
    end
  end

  assign bus.div_ready  = div_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.div_busy   = div_busy_q;
  assign bus.div_result = div_result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: scoreboard bench for ex_div_ctrl. Expected results come from a
// behavioural reference model, are queued at request time and popped when
// out_valid is seen.
module tb_ex_div_ctrl;

  localparam int unsigned XLEN = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif
  localparam int NORM_LAT = 33;

  logic clk = 1'b0;
  logic resetn;

  ex_div_ctrl_if #(.XLEN(XLEN)) bus ();

  ex_div_ctrl #(.XLEN(XLEN), .CNT_W(6)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: native SV division plus the architectural corner cases
  function automatic logic [31:0] ref_div(input logic sgn, input logic md,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) begin
      if (md) return a;
      if (sgn && a[31]) return 32'd1;
      return 32'hFFFF_FFFF;
    end
    if (!sgn) return md ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : 32'h8000_0000;
    sa = int'(a);
    sb = int'(b);
    return md ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency and result, optionally stall the consumer
  task automatic do_op(input logic sgn, input logic md, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] got, e;
    exp_q.push_back(ref_div(sgn, md, a, b));
    bus.div_valid  = 1'b1;
    bus.div_signed = sgn;
    bus.div_mod    = md;
    bus.div_src1   = a;
    bus.div_src2   = b;
    bus.out_ready  = (hold == 0);
    tick();
    bus.div_valid = 1'b0;
    lat = 1;
    check_eq("busy_after_accept", 32'(bus.div_busy), 32'd1);
    check_eq("ready_after_accept", 32'(bus.div_ready), 32'd0);
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq("latency", 32'(lat), (b == 32'd0) ? 32'(ZERO_LAT) : 32'(NORM_LAT));
    e = exp_q.pop_front();
    got = bus.div_result;
    check_eq("result", got, e);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_ready", 32'(bus.div_ready), 32'd0);
      check_eq("hold_result", bus.div_result, e);
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("idle_ready", 32'(bus.div_ready), 32'd1);
    check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    resetn         = 1'b0;
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_mod    = 1'b0;
    bus.div_src1   = '0;
    bus.div_src2   = '0;
    bus.div_flush  = 1'b0;
    bus.out_ready  = 1'b1;
    #12;
    check_eq("rst_ready", 32'(bus.div_ready), 32'd1);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", bus.div_result, 32'd0);
    check_eq("rst_busy", 32'(bus.div_busy), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed operands: unsigned, signed, overflow, divide by zero
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 0);
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 0);
    do_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 0);

    // Backpressure in DONE
    do_op(1'b0, 1'b0, 32'd1000, 32'd33, 10);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            32'($urandom_range(1, 70000)), 0);
    end

    // Flush mid-CALC: no result may appear
    bus.div_valid = 1'b1; bus.div_signed = 1'b0; bus.div_mod = 1'b0;
    bus.div_src1 = 32'd100; bus.div_src2 = 32'd7;
    tick();
    bus.div_valid = 1'b0;
    repeat (15) tick();
    bus.div_flush = 1'b1;
    tick();
    bus.div_flush = 1'b0;
    check_eq("flush_ready", 32'(bus.div_ready), 32'd1);
    check_eq("flush_busy", 32'(bus.div_busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) seen = 1;
    end
    check_eq("flush_no_valid", 32'(seen), 32'd0);
    do_op(1'b0, 1'b0, 32'd20, 32'd3, 0);

    // Flush coincident with a request in IDLE
    bus.div_valid = 1'b1; bus.div_flush = 1'b1;
    bus.div_src1 = 32'd9; bus.div_src2 = 32'd3;
    tick();
    bus.div_valid = 1'b0; bus.div_flush = 1'b0;
    check_eq("flush_acc_busy", 32'(bus.div_busy), 32'd0);
    check_eq("flush_acc_ready", 32'(bus.div_ready), 32'd1);
    tick();
    check_eq("flush_acc_busy2", 32'(bus.div_busy), 32'd0);

    // Asynchronous reset mid-CALC, between clock edges
    bus.div_valid = 1'b1; bus.div_src1 = 32'd50; bus.div_src2 = 32'd5;
    tick();
    bus.div_valid = 1'b0;
    repeat (10) tick();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_ready", 32'(bus.div_ready), 32'd1);
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_busy", 32'(bus.div_busy), 32'd0);
    check_eq("arst_result", bus.div_result, 32'd0);
    #3;
    resetn = 1'b1;
    tick();
    do_op(1'b0, 1'b0, 32'd9, 32'd3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
